// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX, TX and baud-generator paths.
// Frame format: idle-high line, 1 start, UART_DATA_BITS LSB-first data bits, 1 stop.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk latency.
// Both flops reset to RESET_VAL so the synchronized line starts at its idle level.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling, one-clk rx_valid / frame_err strobes.
// Latency: 2 clk synchronizer plus the frame itself; no backpressure, the consumer must take rx_data on rx_valid.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rxs;

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rxs)
    );

    uart_state_e          state_q,     state_d;
    logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_busy_q,   rx_busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Start edge is taken on any clk so back-to-back frames lose at most one tick of phase.
                if (!rxs) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end

            START: begin
                if (os_tick) begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rxs) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (os_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            STOP: begin
                if (os_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rxs) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            WAIT_IDLE: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        rx_busy_d = (state_d != IDLE);
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back, glitch, framing error, mid-frame reset, os_tick stall.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       os_tick = 1'b0;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .os_tick  (os_tick),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    // os_tick every 4 clk, changed on the falling edge; tick_en stalls it.
    logic tick_en = 1'b1;
    int   div_cnt = 0;
    always @(negedge clk) begin
        div_cnt = (div_cnt + 1) % 4;
        os_tick = tick_en && (div_cnt == 0);
    end

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    logic [7:0] got[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                valid_cnt = valid_cnt + 1;
                got.push_back(rx_data);
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (rx_valid && frame_err) both_cnt = both_cnt + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!os_tick && guard < 200);
            if (!os_tick) check("tick_timeout", 32'(os_tick), 32'd1);
        end
    endtask

    task automatic send_bit(input logic b);
        #1 rx_in = b;
        wait_ticks(16);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data",   32'(rx_data),   32'h00);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_rx_busy",   32'(rx_busy),   32'd0);
        rst = 1'b0;
        wait_ticks(4);

        // 0xA5 single frame
        b = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        check("a5_busy_mid", 32'(rx_busy), 32'd1);
        for (int i = 4; i < 8; i++) send_bit(b[i]);
        check("a5_busy_pre_stop", 32'(rx_busy), 32'd1);
        send_bit(1'b1);
        wait_ticks(4);
        check("a5_valid_cnt", 32'(valid_cnt), 32'd1);
        check("a5_got",       32'(got[0]),    32'hA5);
        check("a5_rx_data",   32'(rx_data),   32'hA5);
        check("a5_ferr_cnt",  32'(ferr_cnt),  32'd0);
        check("a5_busy_idle", 32'(rx_busy),   32'd0);

        // back-to-back 0x00, 0xFF
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_ticks(4);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
        check("b2b_first",     32'(got[1]),    32'h00);
        check("b2b_second",    32'(got[2]),    32'hFF);
        check("b2b_ferr_cnt",  32'(ferr_cnt),  32'd0);

        // 4-tick glitch
        #1 rx_in = 1'b0;
        wait_ticks(4);
        check("glitch_busy_start", 32'(rx_busy), 32'd1);
        #1 rx_in = 1'b1;
        wait_ticks(20);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd3);
        check("glitch_ferr_cnt",  32'(ferr_cnt),  32'd0);
        check("glitch_rx_data",   32'(rx_data),   32'hFF);
        check("glitch_busy",      32'(rx_busy),   32'd0);

        // 0x3C with low stop, line held low, then 0x81
        b = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        #1 rx_in = 1'b0;
        wait_ticks(40);
        check("ferr_cnt",        32'(ferr_cnt),  32'd1);
        check("ferr_valid_cnt",  32'(valid_cnt), 32'd3);
        check("ferr_rx_data",    32'(rx_data),   32'hFF);
        check("ferr_busy_break", 32'(rx_busy),   32'd1);
        #1 rx_in = 1'b1;
        wait_ticks(16);
        check("ferr_busy_release", 32'(rx_busy), 32'd0);
        send_byte(8'h81, 1'b1);
        wait_ticks(4);
        check("after_ferr_valid_cnt", 32'(valid_cnt), 32'd4);
        check("after_ferr_rx_data",   32'(rx_data),   32'h81);
        check("after_ferr_ferr_cnt",  32'(ferr_cnt),  32'd1);

        // reset during data bit 4 of 0x55
        b = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        #1 rx_in = b[4];
        wait_ticks(8);
        #1 rst = 1'b1;
        #1;
        check("midrst_rx_data",   32'(rx_data),   32'h00);
        check("midrst_rx_valid",  32'(rx_valid),  32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_rx_busy",   32'(rx_busy),   32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rx_in = 1'b1;
        wait_ticks(20);
        check("postrst_busy", 32'(rx_busy), 32'd0);
        send_byte(8'h96, 1'b1);
        wait_ticks(4);
        check("postrst_rx_data",   32'(rx_data),   32'h96);
        check("postrst_valid_cnt", 32'(valid_cnt), 32'd5);

        // os_tick stall mid-frame on 0xC3
        b = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        #1 rx_in = b[4];
        wait_ticks(8);
        #1 tick_en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("stall_busy",      32'(rx_busy),   32'd1);
        check("stall_valid_cnt", 32'(valid_cnt), 32'd5);
        tick_en = 1'b1;
        wait_ticks(8);
        for (int i = 5; i < 8; i++) send_bit(b[i]);
        send_bit(1'b1);
        wait_ticks(4);
        check("stall_rx_data",   32'(rx_data),   32'hC3);
        check("stall_valid_end", 32'(valid_cnt), 32'd6);
        check("final_ferr_cnt",  32'(ferr_cnt),  32'd1);
        check("never_both",      32'(both_cnt),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: consumes the serial line driven by the transmitter's serial output (idle-high, 1 start, 8 data LSB-first, 1 stop).
- Oversamples the line on a 16x baud tick.
- Samples each bit at mid-bit and reassembles the byte.
- Presents the byte with a single-cycle valid strobe plus a framing-error flag.
- Sits between the pad/loopback wire and the RX byte consumer.

Parameters:
- OVERSAMPLE, 16, os_tick pulses per bit period; even, >= 8.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- os_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  last correctly framed byte; held until next good frame.
- rx_valid  output  1  one-clk pulse, rx_data newly updated.
- frame_err  output  1  one-clk pulse, stop bit sampled low.
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE, tick counter=0, bit counter=0, shift reg=0.
  - rx_data=0, rx_valid=0, frame_err=0, rx_busy=0.
  - Synchronizer flops =1 (idle level).
- rx_in passes through a 2-FF synchronizer; all logic uses the synced value rxs. This gives 2 clk of input latency.
- Counters advance only on clk edges where os_tick=1. With os_tick=0 the FSM holds, except for the IDLE start detection.
- IDLE:
  - rxs=0 -> START, tick_cnt=0.
  - Detection does not require os_tick.
- START:
  - On each os_tick, tick_cnt++.
  - When tick_cnt reaches OVERSAMPLE/2-1 on an os_tick, sample rxs.
  - rxs=0 -> DATA, tick_cnt=0, bit_cnt=0.
  - rxs=1 -> IDLE (glitch rejected; no outputs).
- DATA:
  - On an os_tick with tick_cnt==OVERSAMPLE-1, sample rxs into the shift reg MSB, shifting right (LSB-first reassembly). Then tick_cnt=0, bit_cnt++.
  - After sampling bit DATA_BITS-1 -> STOP.
- STOP:
  - On an os_tick with tick_cnt==OVERSAMPLE-1, sample rxs.
  - rxs=1: rx_data<=shift reg and rx_valid=1 for exactly one clk. Next state IDLE.
  - rxs=0: frame_err=1 for one clk; rx_data unchanged. Next state WAIT_IDLE.
- WAIT_IDLE (break / line-stuck-low): remain until rxs=1, then IDLE. No new frame is accepted while the line stays low.
- Timing:
  - Sampling point is mid-bit: start + OVERSAMPLE/2 ticks.
  - rx_valid/frame_err rise on the clk edge after the os_tick that samples the stop bit.
- Back-to-back frames:
  - A start bit that follows the stop bit immediately is detected on the first IDLE cycle.
  - The resulting phase error of up to one os_tick is acceptable.
- rx_valid and frame_err are never high in the same cycle.
- rx_busy is a registered decode of state, asserted the cycle after START entry.
- Counter widths: tick_cnt $clog2(OVERSAMPLE) bits, bit_cnt $clog2(DATA_BITS)+1 bits. No wrap occurs within a frame.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding IDLE/START/DATA/STOP/WAIT_IDLE.
  - Constants UART_OVERSAMPLE=16, UART_DATA_BITS=8, UART_FRAME_BITS=10.
  - The package is reused by the TX path and the baud generator.
- One sub-module: uart_sync (2-FF synchronizer, parameterised reset value, async active-high reset).

Test Plan:
- Byte 0xA5, framed 0,1,0,1,0,0,1,0,1,1 with each bit held 16 os_ticks and os_tick every 4 clk -> one rx_valid pulse, rx_data=0xA5, frame_err=0, rx_busy high from start through stop sample.
- Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses, rx_data=0x00 then 0xFF, no frame_err.
- Line low for 4 os_ticks then high (glitch) -> return to IDLE, no rx_valid, no frame_err, rx_data unchanged.
- Byte 0x3C with stop bit low, line held low 40 os_ticks, then released -> frame_err pulse once, rx_data keeps previous value. No further start detected until the line rises, after which a following 0x81 is received correctly.
- rst asserted during data bit 4 of 0x55 -> all outputs 0 immediately. A subsequent clean frame 0x96 -> rx_data=0x96.
- os_tick stalled for 50 clk mid-frame on 0xC3 -> FSM holds, then completes with rx_data=0xC3.
